// File: rtl/rv_namec_mem_resp.sv
// Memory responder at the target end of the rv_namec load/store bus.
// It accepts one request at a time, holds it for WAIT_CYCLES wait states,
// then presents a read word or a write acknowledge with an error flag.
// The FSM state is exported on state_dbg so external checkers can bind to it.
//
// Handshake rule: a transfer on either channel happens on a rising edge
// where valid and ready are both 1. A valid source holds its payload
// stable until that edge. req_ready is only high in IDLE. rsp_valid is
// only high in RESP, so the request and response channels never complete
// a transfer in the same cycle.
module rv_namec_mem_resp #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic              rv_namec_mem_resp_clock,
  input  logic              rv_namec_mem_resp_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       txn_count,
  output logic [1:0]        state_dbg
);

  localparam int unsigned     IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN      = (ADDR_W+1)'(DEPTH_WORDS) << 2;
  localparam bit              HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]      WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic [ADDR_W-1:0] offset;
  logic              dec_err;
  logic [IDX_W-1:0]  dec_idx;
  logic              enter_resp;
  logic              do_write;
  logic [31:0]       rsp_word;

  assign state_dbg = state;

  // Decode the request that is about to be serviced. With no wait states the
  // live request is decoded directly in IDLE, otherwise the latched copy.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == ST_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
    offset     = cur_addr - BASE_ADDR;
    dec_err    = (cur_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    dec_idx    = offset[IDX_W+1:2];
    enter_resp = 1'b0;
    if (state == ST_IDLE) begin
      enter_resp = req_valid && !HAS_WAIT;
    end else if (state == ST_WAIT) begin
      enter_resp = (wait_cnt == 4'd0);
    end
    rsp_word = (dec_err || cur_we) ? 32'h0 : mem[dec_idx];
    do_write = enter_resp && cur_we && !dec_err && !rv_namec_mem_resp_reset;
  end

  // Byte-merged write into the array, committed on the edge that enters RESP.
  always_ff @(posedge rv_namec_mem_resp_clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem[dec_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs and transaction counter.
  always_ff @(posedge rv_namec_mem_resp_clock) begin
    if (rv_namec_mem_resp_reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      txn_count <= 32'h0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      lat_be    <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            req_ready <= 1'b0;
            if (HAS_WAIT) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_word;
              rsp_err   <= dec_err;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_word;
            rsp_err   <= dec_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            txn_count <= txn_count + 32'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_namec_mem_resp.sv
// Bench for rv_namec_mem_resp: one instance with two wait states (index 0)
// and one with none (index 1), checked every cycle against a transaction
// level model plus directed literal expectations.
`timescale 1ns/1ps
module tb_rv_namec_mem_resp;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] txn_count [2];
  logic [1:0]  state_dbg [2];

  rv_namec_mem_resp #(.WAIT_CYCLES(2)) u_w2 (
    .rv_namec_mem_resp_clock(clk), .rv_namec_mem_resp_reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .txn_count(txn_count[0]), .state_dbg(state_dbg[0]));

  rv_namec_mem_resp #(.WAIT_CYCLES(0)) u_w0 (
    .rv_namec_mem_resp_clock(clk), .rv_namec_mem_resp_reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .txn_count(txn_count[1]), .state_dbg(state_dbg[1]));

  int n_pass   = 0;
  int n_total  = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  function automatic int waits_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic string nm(input int d);
    return (d == 0) ? "w2" : "w0";
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard model: transaction-level view of each responder.
  bit          m_ready [2];
  bit          m_valid [2];
  bit          m_err   [2];
  bit          m_pend  [2];
  bit          m_we    [2];
  logic [31:0] m_rdata [2];
  logic [31:0] m_count [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be    [2];
  int          m_due   [2];
  logic [31:0] m_mem [int];

  function automatic void m_respond(input int d);
    logic [31:0] off;
    logic [31:0] word;
    int key;
    off        = m_addr[d] - 32'h0000_0000;
    m_pend[d]  = 1'b0;
    m_valid[d] = 1'b1;
    m_rdata[d] = 32'h0;
    m_err[d]   = (m_addr[d][1:0] != 2'b00) || (off >= 32'd4096);
    if (!m_err[d]) begin
      key  = d * 1024 + int'(off >> 2);
      word = m_mem.exists(key) ? m_mem[key] : 32'h0;
      if (m_we[d]) begin
        for (int i = 0; i < 4; i++) begin
          if (m_be[d][i]) word[8*i +: 8] = m_wdata[d][8*i +: 8];
        end
        m_mem[key] = word;
      end else begin
        m_rdata[d] = word;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ready[d] = 1'b1; m_valid[d] = 1'b0; m_err[d] = 1'b0; m_pend[d] = 1'b0;
        m_rdata[d] = 32'h0; m_count[d] = 32'h0;
      end else if (m_valid[d]) begin
        if (rsp_ready[d]) begin
          m_count[d] = m_count[d] + 32'd1;
          m_valid[d] = 1'b0; m_rdata[d] = 32'h0; m_err[d] = 1'b0;
          m_ready[d] = 1'b1;
        end
      end else if (m_ready[d]) begin
        if (req_valid[d]) begin
          m_we[d] = req_we[d]; m_addr[d] = req_addr[d];
          m_wdata[d] = req_wdata[d]; m_be[d] = req_be[d];
          m_ready[d] = 1'b0; m_pend[d] = 1'b1;
          m_due[d] = cyc + waits_of(d);
          if (m_due[d] == cyc) m_respond(d);
        end
      end else if (m_pend[d] && cyc == m_due[d]) begin
        m_respond(d);
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        chk({nm(d), ".req_ready"}, 32'(req_ready[d]), 32'(m_ready[d]));
        chk({nm(d), ".rsp_valid"}, 32'(rsp_valid[d]), 32'(m_valid[d]));
        chk({nm(d), ".rsp_rdata"}, rsp_rdata[d], m_rdata[d]);
        chk({nm(d), ".rsp_err"}, 32'(rsp_err[d]), 32'(m_err[d]));
        chk({nm(d), ".txn_count"}, txn_count[d], m_count[d]);
      end
    end
  end

  // Driver tasks (called at a falling edge)
  task automatic send(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, output int acc);
    int n;
    n = 0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) begin
      n_total++;
      $display("FAIL %s.accept_timeout: req_ready stayed 0, expected 1", nm(d));
    end
    acc = cyc;
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom_range(0, 15));
  endtask

  task automatic recv(input int d, input int hold, output logic [31:0] rd,
                      output logic er, output int vcyc);
    int n;
    n = 0;
    while (!rsp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) begin
      n_total++;
      $display("FAIL %s.rsp_timeout: rsp_valid stayed 0, expected 1", nm(d));
    end
    vcyc = cyc; rd = rsp_rdata[d]; er = rsp_err[d];
    repeat (hold) @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int acc;
    int vcyc;
    logic [31:0] rd;
    logic er;
    send(d, we, addr, wdata, be, acc);
    recv(d, hold, rd, er, vcyc);
    chk({tag, "_latency"}, 32'(vcyc - acc), 32'(waits_of(d) + 1));
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int acc;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checking = 1'b1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk({nm(d), "_reset_req_ready"}, 32'(req_ready[d]), 32'd1);
      chk({nm(d), "_reset_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
      chk({nm(d), "_reset_count"}, txn_count[d], 32'd0);
      rsp_ready[d] = 1'b1;
    end
    // rsp_ready high while idle does nothing
    repeat (3) @(negedge clk);
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    chk("idle_rsp_ready_count", txn_count[0], 32'd0);

    // Full write then read-back
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "wr_10");
    chk("wr_10_count", txn_count[0], 32'd1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "rd_10");

    // Partial writes and the be=0 no-op
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 1'b0, "wr_20");
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1'b0, "wr_20_be5");
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h11BB33DD, 1'b0, "rd_20_merged");
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 1'b0, "wr_20_be0");
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h11BB33DD, 1'b0, "rd_20_after_be0");

    // Error decode and no aliasing of out-of-range writes
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, "wr_0");
    txn(0, 1'b0, 32'h22, 32'h0, 4'hF, 0, 32'h0, 1'b1, "rd_misaligned");
    txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, 32'h0, 1'b1, "rd_out_of_range");
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 0, 32'h0, 1'b1, "wr_out_of_range");
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1'b0, "rd_0_no_alias");

    // Backpressure: five stalled cycles, handshake on the sixth
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDEADBEEF, 1'b0, "rd_backpressure");
    chk("ready_after_backpressure", 32'(req_ready[0]), 32'd1);

    // Zero-wait instance: fill four words
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 0, 32'h0, 1'b0, "w0_wr");
    end

    // Reset while a write sits in WAIT
    txn(0, 1'b1, 32'h30, 32'h0, 4'hF, 0, 32'h0, 1'b0, "wr_30_zero");
    send(0, 1'b1, 32'h30, 32'h55, 4'hF, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("midrst_count", txn_count[0], 32'd0);
    txn(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, 32'h0, 1'b0, "rd_30_after_rst");
    chk("midrst_count_after_read", txn_count[0], 32'd1);

    // Zero-wait back-to-back reads
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, 0, 32'hA0 + 32'(i), 1'b0, "w0_rd");
    end
    chk("w0_count_after_reads", txn_count[1], 32'd4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
